// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master side (controller or bench) drives the request and operands.
// The slave side (the serial unit) returns status and the result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             M;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Ts;
    logic             V;

    modport master (
        output start, M, A, B,
        input  ready, busy, done, S, Ts, V
    );

    modport slave (
        input  start, M, A, B,
        output ready, busy, done, S, Ts, V
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor.
// One full adder/subtractor cell is reused over WIDTH clocks, LSB first.
// The carry (M=0) or borrow (M=1) is held in a register between bits.
// Status follows the state: ready in IDLE, busy in RUN, done for the single DONE cycle.
// S/Ts/V hold the last result until the final bit of the next operation is computed.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic [WIDTH-1:0] aSh;
    logic [WIDTH-1:0] bSh;
    logic [WIDTH-1:0] resSh;
    logic [WIDTH-1:0] sReg;
    logic             mode;
    logic             t;
    logic             tsReg;
    logic             vReg;
    logic [CW-1:0]    cnt;

    logic             a0;
    logic             b0;
    logic             sBit;
    logic             tNext;
    logic [WIDTH-1:0] resNext;

    // Single adder/subtractor cell acting on the current operand LSBs and the held carry/borrow.
    always_comb begin
        a0      = aSh[0];
        b0      = bSh[0];
        sBit    = a0 ^ b0 ^ t;
        tNext   = mode ? ((~a0 & b0) | (~a0 & t) | (b0 & t))
                       : ((a0 & b0) | (a0 & t) | (b0 & t));
        resNext = {sBit, resSh[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: start is only honoured in IDLE, and DONE always lasts one cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = RUN;
            RUN:     if (cnt == LAST) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, then shift one bit per RUN cycle and publish the result on the MSB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aSh   <= '0;
            bSh   <= '0;
            resSh <= '0;
            sReg  <= '0;
            mode  <= 1'b0;
            t     <= 1'b0;
            tsReg <= 1'b0;
            vReg  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        aSh  <= bus.A;
                        bSh  <= bus.B;
                        mode <= bus.M;
                        t    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    aSh   <= aSh >> 1;
                    bSh   <= bSh >> 1;
                    resSh <= resNext;
                    t     <= tNext;
                    if (cnt == LAST) begin
                        sReg  <= resNext;
                        tsReg <= tNext;
                        vReg  <= t ^ tNext;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.S     = sReg;
    assign bus.Ts    = tsReg;
    assign bus.V     = vReg;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub.
// An 8-bit instance covers handshake, timing, reset and random arithmetic.
// A 4-bit instance is swept over every mode/operand combination.
// Expected results come from a plain-arithmetic reference model.
module tb_serial_addsub;

    logic clk;
    logic rst_n;

    int nVec;
    int nErr;

    serial_addsub_if #(.WIDTH(8)) bus8 ();
    serial_addsub_if #(.WIDTH(4)) bus4 ();

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer add/subtract reduced modulo 2^w, with carry/borrow and signed overflow from operand signs.
    function automatic void model(input int w, input int m, input int a, input int b,
                                  output int s, output int ts, output int v);
        int full;
        int sa;
        int sb;
        int sr;
        if (m == 0) begin
            full = a + b;
            ts   = (full >= (1 << w)) ? 1 : 0;
        end else begin
            full = a - b;
            ts   = (a < b) ? 1 : 0;
        end
        s  = full & ((1 << w) - 1);
        sa = (a >> (w - 1)) & 1;
        sb = (b >> (w - 1)) & 1;
        sr = (s >> (w - 1)) & 1;
        if (m == 0) v = ((sa == sb) && (sr != sa)) ? 1 : 0;
        else        v = ((sa != sb) && (sr != sa)) ? 1 : 0;
    endfunction

    // One 8-bit operation: checks RUN length, S hold during RUN, the done pulse and the result.
    task automatic runOp8(input logic m, input logic [7:0] a, input logic [7:0] b, input string tag);
        int es, et, ev;
        int busyCnt;
        bit seen;
        bit heldOk;
        logic [7:0] prevS;
        model(8, int'(m), int'(a), int'(b), es, et, ev);
        @(negedge clk);
        prevS      = bus8.S;
        bus8.M     = m;
        bus8.A     = a;
        bus8.B     = b;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        busyCnt = 0;
        seen    = 1'b0;
        heldOk  = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (bus8.done) begin
                seen = 1'b1;
                break;
            end
            if (bus8.busy) busyCnt++;
            if (bus8.S !== prevS || bus8.ready !== 1'b0) heldOk = 1'b0;
            @(negedge clk);
        end
        nVec++;
        if (seen !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL %s done_timeout: got seen=%0d, want 1", tag, seen);
        end
        nVec++;
        if (busyCnt !== 8) begin
            nErr++;
            $display("[TB] FAIL %s busy_cycles: got %0d, want 8", tag, busyCnt);
        end
        nVec++;
        if (heldOk !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL %s hold_during_run: S or ready changed before the result cycle", tag);
        end
        nVec++;
        if ({bus8.S, bus8.Ts, bus8.V} !== {8'(es), 1'(et), 1'(ev)}) begin
            nErr++;
            $display("[TB] FAIL %s result: got S=%h Ts=%b V=%b, want S=%h Ts=%0d V=%0d",
                     tag, bus8.S, bus8.Ts, bus8.V, 8'(es), et, ev);
        end
        @(negedge clk);
        nVec++;
        if ({bus8.done, bus8.ready, bus8.busy} !== 3'b010) begin
            nErr++;
            $display("[TB] FAIL %s after_done: got done/ready/busy=%b, want 010", tag,
                     {bus8.done, bus8.ready, bus8.busy});
        end
    endtask

    // Reset values on both instances.
    task automatic test_reset();
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.M     = 1'b0;
        bus8.A     = '0;
        bus8.B     = '0;
        bus4.start = 1'b0;
        bus4.M     = 1'b0;
        bus4.A     = '0;
        bus4.B     = '0;
        #12;
        nVec++;
        if ({bus8.ready, bus8.busy, bus8.done, bus8.S, bus8.Ts, bus8.V} !== {3'b100, 8'h00, 2'b00}) begin
            nErr++;
            $display("[TB] FAIL reset8: got r/b/d=%b%b%b S=%h Ts=%b V=%b, want 100 00 0 0",
                     bus8.ready, bus8.busy, bus8.done, bus8.S, bus8.Ts, bus8.V);
        end
        nVec++;
        if ({bus4.ready, bus4.busy, bus4.done, bus4.S, bus4.Ts, bus4.V} !== {3'b100, 4'h0, 2'b00}) begin
            nErr++;
            $display("[TB] FAIL reset4: got r/b/d=%b%b%b S=%h Ts=%b V=%b, want 100 0 0 0",
                     bus4.ready, bus4.busy, bus4.done, bus4.S, bus4.Ts, bus4.V);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed carry, overflow and borrow corners.
    task automatic test_directed();
        runOp8(1'b0, 8'h3C, 8'h05, "add_3c_05");
        runOp8(1'b0, 8'hFF, 8'h01, "add_ff_01");
        runOp8(1'b0, 8'h7F, 8'h01, "add_7f_01");
        runOp8(1'b1, 8'h05, 8'h07, "sub_05_07");
        runOp8(1'b1, 8'h80, 8'h01, "sub_80_01");
        runOp8(1'b1, 8'h00, 8'h00, "sub_00_00");
    endtask

    // Random operands and modes.
    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            runOp8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), "random");
        end
    endtask

    // Input changes and start pulses during RUN are ignored; start held high chains operations.
    task automatic test_handshake();
        int dones;
        bit seen;
        @(negedge clk);
        bus8.M = 1'b0; bus8.A = 8'h3C; bus8.B = 8'h05; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        bus8.M = 1'b1; bus8.A = 8'hAA; bus8.B = 8'h55; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (bus8.done) seen = 1'b1;
        end
        nVec++;
        if ({seen, bus8.S, bus8.Ts, bus8.V} !== {1'b1, 8'h41, 2'b00}) begin
            nErr++;
            $display("[TB] FAIL hs_latched: got seen=%b S=%h Ts=%b V=%b, want 1 41 0 0",
                     seen, bus8.S, bus8.Ts, bus8.V);
        end
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus8.done) dones++;
        end
        nVec++;
        if (dones !== 0) begin
            nErr++;
            $display("[TB] FAIL hs_extra_done: got %0d extra done pulses, want 0", dones);
        end

        bus8.M = 1'b0; bus8.A = 8'h10; bus8.B = 8'h20; bus8.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus8.A = 8'h7F; bus8.B = 8'h01;
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (bus8.done) seen = 1'b1;
        end
        nVec++;
        if ({seen, bus8.S, bus8.Ts, bus8.V} !== {1'b1, 8'h30, 2'b00}) begin
            nErr++;
            $display("[TB] FAIL b2b_first: got seen=%b S=%h Ts=%b V=%b, want 1 30 0 0",
                     seen, bus8.S, bus8.Ts, bus8.V);
        end
        @(negedge clk);
        nVec++;
        if (bus8.ready !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL b2b_ready: got ready=%b, want 1", bus8.ready);
        end
        @(negedge clk);
        bus8.start = 1'b0;
        nVec++;
        if (bus8.busy !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL b2b_accept: got busy=%b, want 1", bus8.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (bus8.done) seen = 1'b1;
        end
        nVec++;
        if ({seen, bus8.S, bus8.Ts, bus8.V} !== {1'b1, 8'h80, 2'b01}) begin
            nErr++;
            $display("[TB] FAIL b2b_second: got seen=%b S=%h Ts=%b V=%b, want 1 80 0 1",
                     seen, bus8.S, bus8.Ts, bus8.V);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset while the fourth bit is being processed abandons the operation.
    task automatic test_reset_mid();
        int dones;
        runOp8(1'b0, 8'hF0, 8'h0F, "pre_reset");
        @(negedge clk);
        bus8.M = 1'b0; bus8.A = 8'h55; bus8.B = 8'h33; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nVec++;
        if ({bus8.ready, bus8.busy, bus8.done, bus8.S, bus8.Ts, bus8.V} !== {3'b100, 8'h00, 2'b00}) begin
            nErr++;
            $display("[TB] FAIL mid_reset: got r/b/d=%b%b%b S=%h Ts=%b V=%b, want 100 00 0 0",
                     bus8.ready, bus8.busy, bus8.done, bus8.S, bus8.Ts, bus8.V);
        end
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus8.done) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) dones++;
        end
        nVec++;
        if (dones !== 0) begin
            nErr++;
            $display("[TB] FAIL mid_reset_done: got %0d done pulses, want 0", dones);
        end
        runOp8(1'b0, 8'h01, 8'h01, "post_reset");
    endtask

    // Every mode/operand pair on the 4-bit instance.
    task automatic test_sweep4();
        int es, et, ev;
        bit seen;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    model(4, m, a, b, es, et, ev);
                    @(negedge clk);
                    bus4.M = 1'(m); bus4.A = 4'(a); bus4.B = 4'(b); bus4.start = 1'b1;
                    @(negedge clk);
                    bus4.start = 1'b0;
                    seen = 1'b0;
                    for (int i = 0; i < 16 && !seen; i++) begin
                        if (bus4.done) seen = 1'b1;
                        else @(negedge clk);
                    end
                    nVec++;
                    if ({seen, bus4.S, bus4.Ts, bus4.V} !== {1'b1, 4'(es), 1'(et), 1'(ev)}) begin
                        nErr++;
                        $display("[TB] FAIL sweep4 M=%0d A=%h B=%h: got seen=%b S=%h Ts=%b V=%b, want 1 %h %0d %0d",
                                 m, a, b, seen, bus4.S, bus4.Ts, bus4.V, 4'(es), et, ev);
                    end
                end
            end
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        nVec = 0;
        nErr = 0;
        test_reset();
        test_directed();
        test_random();
        test_handshake();
        test_reset_mid();
        test_sweep4();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
